// File: rtl/bm_pack_if.sv
// Burst/byte-buffer/word-output signal bundle for bm_pack.
// master drives requests and the byte stream; slave is the packer.
interface bm_pack_if;
    logic        start;
    logic [12:0] len;
    logic        abort;
    logic        bm_req;
    logic [7:0]  bm_q;
    logic        bm_qvld;
    logic [31:0] word_data;
    logic        word_vld;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, len, abort, bm_q, bm_qvld,
        input  bm_req, word_data, word_vld, busy, done, err
    );

    modport slave (
        input  start, len, abort, bm_q, bm_qvld,
        output bm_req, word_data, word_vld, busy, done, err
    );
endinterface

// File: rtl/bm_pack.sv
// Packs an MSB-first byte stream into 32-bit words for a burst of len words,
// with per-byte inactivity timeout and immediate abort.
module bm_pack #(
    parameter logic [15:0] TO_CYC = 16'd1024
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    bm_pack_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] part;
    logic [12:0] word_cnt;
    logic [12:0] len_r;
    logic [15:0] to_cnt;

    // Bytes are only taken while RUN, so anything after bm_req falls is dropped.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            byte_cnt      <= 2'd0;
            part          <= 24'h0;
            word_cnt      <= 13'd0;
            len_r         <= 13'd0;
            to_cnt        <= 16'd0;
            bus.bm_req    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.word_data <= 32'h0;
            bus.word_vld  <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.word_vld <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            if (bus.abort) begin
                state      <= IDLE;
                bus.bm_req <= 1'b0;
                bus.busy   <= 1'b0;
                byte_cnt   <= 2'd0;
                word_cnt   <= 13'd0;
                to_cnt     <= 16'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (bus.len == 13'd0) begin
                                bus.done <= 1'b1;
                            end else begin
                                state      <= RUN;
                                bus.bm_req <= 1'b1;
                                bus.busy   <= 1'b1;
                                len_r      <= bus.len;
                                byte_cnt   <= 2'd0;
                                word_cnt   <= 13'd0;
                                to_cnt     <= 16'd0;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.bm_qvld) begin
                            // An accepted byte always wins over a coincident timeout.
                            to_cnt   <= 16'd0;
                            part     <= {part[15:0], bus.bm_q};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                bus.word_data <= {part, bus.bm_q};
                                bus.word_vld  <= 1'b1;
                                word_cnt      <= word_cnt + 13'd1;
                                if (word_cnt + 13'd1 == len_r) begin
                                    state      <= IDLE;
                                    bus.bm_req <= 1'b0;
                                    bus.busy   <= 1'b0;
                                    bus.done   <= 1'b1;
                                end
                            end
                        end else if (to_cnt == TO_CYC - 16'd1) begin
                            state      <= IDLE;
                            bus.bm_req <= 1'b0;
                            bus.busy   <= 1'b0;
                            bus.err    <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        bus.bm_req <= 1'b0;
                        bus.busy   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bm_pack.sv
// Directed bench for bm_pack with hand-computed expected words and pulses.
module tb_bm_pack;
    logic clk_sys = 1'b0;
    logic rst_n;

    bm_pack_if bus ();

    always #5 clk_sys = ~clk_sys;

    bm_pack #(.TO_CYC(16'd8)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int n_words, n_done, n_err, n_req;
    logic [31:0] last_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        n_words = 0; n_done = 0; n_err = 0; n_req = 0;
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
        if (bus.word_vld) begin
            n_words++;
            last_word = bus.word_data;
        end
        if (bus.done)   n_done++;
        if (bus.err)    n_err++;
        if (bus.bm_req) n_req++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.bm_q    = b;
        bus.bm_qvld = 1'b1;
        step();
        bus.bm_qvld = 1'b0;
    endtask

    task automatic kick(input logic [12:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] b4 [4];
        bus.start = 1'b0; bus.len = 13'd0; bus.abort = 1'b0;
        bus.bm_q = 8'h0;  bus.bm_qvld = 1'b0;
        last_word = 32'h0;
        clr_stats();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_word_data", bus.word_data, 32'h0);
        check("rst_flags", {28'h0, bus.bm_req, bus.busy, bus.word_vld, bus.done | bus.err}, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // len=2, eight back-to-back bytes
        clr_stats();
        kick(13'd2);
        check("s1_req_up", {31'h0, bus.bm_req}, 32'h1);
        check("s1_busy_up", {31'h0, bus.busy}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h11 + 8'(i));
            if (i == 3) begin
                check("s1_w0_vld", {31'h0, bus.word_vld}, 32'h1);
                check("s1_w0", bus.word_data, 32'h11121314);
                check("s1_w0_nodone", {31'h0, bus.done}, 32'h0);
            end
        end
        check("s1_w1", bus.word_data, 32'h15161718);
        check("s1_done", {31'h0, bus.done}, 32'h1);
        check("s1_req_down", {31'h0, bus.bm_req}, 32'h0);
        idle(1);
        check("s1_vld_pulse", {31'h0, bus.word_vld}, 32'h0);
        check("s1_hold", bus.word_data, 32'h15161718);
        check("s1_counts", {8'(n_words), 8'(n_done), 8'(n_err), 8'h0}, {8'd2, 8'd1, 8'd0, 8'h0});

        // len=1 with 3-cycle gaps
        clr_stats();
        kick(13'd1);
        b4[0] = 8'hAA; b4[1] = 8'hBB; b4[2] = 8'hCC; b4[3] = 8'hDD;
        for (int i = 0; i < 4; i++) begin
            send_byte(b4[i]);
            if (i < 3) idle(3);
        end
        check("s2_vld", {31'h0, bus.word_vld}, 32'h1);
        check("s2_word", bus.word_data, 32'hAABBCCDD);
        check("s2_done", {31'h0, bus.done}, 32'h1);
        check("s2_nwords", 32'(n_words), 32'd1);

        // timeout with TO_CYC=8
        clr_stats();
        kick(13'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(7);
        check("s3_no_err_yet", {31'h0, bus.err}, 32'h0);
        idle(1);
        check("s3_err", {31'h0, bus.err}, 32'h1);
        check("s3_busy", {31'h0, bus.busy}, 32'h0);
        idle(1);
        check("s3_err_pulse", {31'h0, bus.err}, 32'h0);
        check("s3_words", 32'(n_words), 32'd0);

        // final byte on the timeout terminal cycle
        clr_stats();
        kick(13'd1);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        idle(7);
        send_byte(8'hA4);
        check("s3b_word", bus.word_data, 32'hA1A2A3A4);
        check("s3b_done", {31'h0, bus.done}, 32'h1);
        check("s3b_no_err", 32'(n_err), 32'd0);

        // abort together with byte 3, then a clean burst
        clr_stats();
        kick(13'd1);
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
        bus.abort = 1'b1;
        send_byte(8'h24);
        bus.abort = 1'b0;
        check("s4_abort_flags", {29'h0, bus.word_vld, bus.done, bus.busy}, 32'h0);
        idle(2);
        check("s4_abort_counts", {16'(n_words), 16'(n_done)}, 32'h0);
        kick(13'd1);
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
        check("s4_after", bus.word_data, 32'h31323334);
        check("s4_after_done", {31'h0, bus.done}, 32'h1);

        // len=0, then start ignored in RUN
        clr_stats();
        kick(13'd0);
        check("s5_zero_done", {31'h0, bus.done}, 32'h1);
        idle(2);
        check("s5_zero_noreq", 32'(n_req), 32'd0);
        check("s5_zero_pulse", 32'(n_done), 32'd1);
        clr_stats();
        kick(13'd2);
        for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i));
        kick(13'd1);
        check("s5_mid_nodone", 32'(n_done), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h51 + 8'(i));
        check("s5_words", {16'(n_words), 16'(n_done)}, {16'd2, 16'd1});
        check("s5_last", last_word, 32'h51525354);

        // reset mid-word, no resume
        kick(13'd1);
        send_byte(8'h61); send_byte(8'h62);
        rst_n = 1'b0;
        #1;
        check("s6_rst_data", bus.word_data, 32'h0);
        check("s6_rst_flags", {30'h0, bus.bm_req, bus.busy}, 32'h0);
        idle(2);
        rst_n = 1'b1;
        clr_stats();
        for (int i = 0; i < 4; i++) send_byte(8'h71 + 8'(i));
        idle(1);
        check("s6_no_resume", {16'(n_words), 16'(n_req)}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bm_pack.md
BM_PACK -- requirements
Module: bm_pack

Interface
REQ-001 SHALL have parameter TO_CYC, default 16'd1024, meaning idle cycles without a byte before a burst is aborted with an error.
REQ-002 SHALL have port clk_sys, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, single-cycle burst request; sampled only in IDLE.
REQ-005 SHALL have port len, input, 13, number of 32-bit words in the burst; sampled with start.
REQ-006 SHALL have port abort, input, 1, terminates any burst immediately.
REQ-007 SHALL have port bm_req, output, 1, level request to the byte buffer; high only in RUN.
REQ-008 SHALL have port bm_q, input, 8, byte stream from the buffer.
REQ-009 SHALL have port bm_qvld, input, 1, bm_q valid this cycle.
REQ-010 SHALL have port word_data, output, 32, reassembled word.
REQ-011 SHALL have port word_vld, output, 1, one-cycle strobe qualifying word_data.
REQ-012 SHALL have port busy, output, 1, high in RUN.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on normal burst completion.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on timeout.

Function
REQ-015 SHALL implement FSM states IDLE and RUN (2-bit encoding; unused codes return to IDLE next cycle).
REQ-016 IDLE -> RUN SHALL occur on the cycle after start=1 with len!=0; start with len==0 SHALL raise done for one cycle and remain in IDLE.
REQ-017 On entering RUN: byte counter, word counter and timeout counter SHALL be cleared, and len SHALL be latched into an internal register.
REQ-018 bm_req SHALL be a registered output equal to (state==RUN).
REQ-019 In RUN, each cycle with bm_qvld=1 SHALL accept bm_q; bm_qvld in IDLE SHALL be ignored.
REQ-020 Byte order SHALL be MSB-first: byte 0 -> word[31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-021 On acceptance of byte 3, word_data SHALL update and word_vld SHALL pulse on the next cycle (1-cycle latency from the fourth byte).
REQ-022 word_data SHALL hold its last value between strobes.
REQ-023 Word counter (13 bits) SHALL increment per emitted word; when it reaches the latched len, the FSM SHALL go to IDLE, and done SHALL pulse in the same cycle as the final word_vld.
REQ-024 Bytes presented with bm_qvld on the cycle bm_req falls or later SHALL be discarded.
REQ-025 Timeout counter (16 bits) SHALL clear on each accepted byte and increment otherwise in RUN; on reaching TO_CYC-1 the FSM SHALL go to IDLE, err SHALL pulse, and the partial word SHALL be discarded with no word_vld.
REQ-026 abort=1 SHALL force IDLE on the next cycle from any state with no done, err or word_vld; abort has priority over start, word completion and timeout in the same cycle.
REQ-027 If the final byte and the timeout terminal count coincide, the word SHALL be emitted with done, and err SHALL NOT pulse.
REQ-028 start asserted in RUN SHALL be ignored.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, with bm_req=0, busy=0, word_vld=0, done=0, err=0, word_data=32'h0, and all counters at 0.
REQ-030 Reset deassertion mid-burst SHALL NOT resume the burst; a new start is required.

Verification
REQ-031 start with len=2, then 8 consecutive valid bytes 11..18 -> word_vld twice with 32'h11121314 and 32'h15161718; done with the second strobe; bm_req low the next cycle.
REQ-032 start with len=1, bytes AA,BB,CC,DD with bm_qvld gaps of 3 cycles -> single word 32'hAABBCCDD, one cycle after DD.
REQ-033 TO_CYC=8, len=1, two bytes then bm_qvld held low -> err pulse after 8 idle cycles, no word_vld, busy=0.
REQ-034 abort asserted together with byte 3 of the first word -> no word_vld, no done, IDLE next cycle; a following start with len=1 works normally.
REQ-035 start with len=0 -> done pulse, bm_req never asserted; start during RUN -> no effect on word count.
REQ-036 rst_n pulled low mid-word -> all outputs at reset values immediately; extra bm_qvld bytes after release -> no word_vld.
